// File: rtl/shift_unit_pkg.sv
// Shared widths, operation codes and FSM state encoding for the multicycle shift unit.
package shift_unit_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_SLL = 3'b001;
    localparam logic [2:0] OP_SRL = 3'b010;
    localparam logic [2:0] OP_SRA = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;
    localparam logic [2:0] OP_ROR = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // NOP and the reserved codes complete without shifting.
    function automatic logic is_shift_op(input logic [2:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA) ||
               (op == OP_ROL) || (op == OP_ROR);
    endfunction

endpackage

// File: rtl/shift_step.sv
// One-bit shift/rotate of a data word; purely combinational.
module shift_step
    import shift_unit_pkg::*;
(
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o
);

    always_comb begin
        q_o = d_i;
        case (op_i)
            OP_SLL:  q_o = {d_i[DATA_W-2:0], 1'b0};
            OP_SRL:  q_o = {1'b0, d_i[DATA_W-1:1]};
            OP_SRA:  q_o = {d_i[DATA_W-1], d_i[DATA_W-1:1]};
            OP_ROL:  q_o = {d_i[DATA_W-2:0], d_i[DATA_W-1]};
            OP_ROR:  q_o = {d_i[0], d_i[DATA_W-1:1]};
            default: q_o = d_i;
        endcase
    end

endmodule

// File: rtl/shift_unit.sv
// Multicycle shifter: one bit position per clock, done pulses for one cycle at the end.
// Handshake: start is accepted at a rising edge only in IDLE or DONE; done is a one-cycle pulse.
module shift_unit
    import shift_unit_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [DATA_W-1:0]  data_in,
    output logic [DATA_W-1:0]  data_out,
    output logic               busy,
    output logic               done
);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   data_q,  data_d;
    logic [SHAMT_W-1:0]  count_q, count_d;
    logic [2:0]          op_q,    op_d;
    logic [DATA_W-1:0]   step_out;

    shift_step u_step (
        .op_i (op_q),
        .d_i  (data_q),
        .q_o  (step_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            count_q <= '0;
            op_q    <= OP_NOP;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
        op_d    = op_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    data_d  = data_in;
                    op_d    = op;
                    count_d = shamt;
                    if ((shamt == '0) || !is_shift_op(op))
                        state_d = ST_DONE;
                    else
                        state_d = ST_SHIFT;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                data_d  = step_out;
                count_d = count_q - SHAMT_W'(1);
                if (count_q == SHAMT_W'(1))
                    state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign data_out = data_q;
    assign busy     = (state_q == ST_SHIFT);
    assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_shift_unit.sv
// Self-checking bench for shift_unit: directed table, hand sequences, random ops vs. arithmetic model.
module tb_shift_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [4:0]  shamt;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        busy;
    logic        done;

    int n_tests;
    int n_fail;

    shift_unit dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .shamt    (shamt),
        .data_in  (data_in),
        .data_out (data_out),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  shamt;
        logic [31:0] data;
        logic [31:0] exp_data;
        int          exp_lat;
        string       name;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference result computed directly with whole-word arithmetic.
    function automatic logic [31:0] model(input logic [2:0] o, input logic [4:0] s, input logic [31:0] d);
        int n;
        n = int'(s);
        case (o)
            3'b001:  return d << n;
            3'b010:  return d >> n;
            3'b011:  return 32'($signed(d) >>> n);
            3'b100:  return (n == 0) ? d : ((d << n) | (d >> (32 - n)));
            3'b101:  return (n == 0) ? d : ((d >> n) | (d << (32 - n)));
            default: return d;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] o, input logic [4:0] s);
        if (o >= 3'b001 && o <= 3'b101 && s != 5'd0)
            return int'(s) + 1;
        return 1;
    endfunction

    // Launch one operation, scramble inputs after accept, and check result and timing.
    task automatic run_op(input logic [2:0] o, input logic [4:0] s, input logic [31:0] d,
                          input logic [31:0] exp_d, input int exp_lat, input string name);
        int cyc;
        int busy_n;
        @(negedge clk);
        start = 1'b1; op = o; shamt = s; data_in = d;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        op      = 3'($urandom_range(0, 7));
        shamt   = 5'($urandom_range(0, 31));
        data_in = $urandom;
        cyc = 1;
        busy_n = 0;
        while (!done && cyc < 64) begin
            if (busy) busy_n++;
            @(negedge clk);
            cyc++;
        end
        check({name, " latency"}, 32'(cyc), 32'(exp_lat));
        check({name, " data"}, data_out, exp_d);
        check({name, " busy cycles"}, 32'(busy_n), 32'(exp_lat - 1));
        @(negedge clk);
        check({name, " done one cycle"}, {31'd0, done}, 32'd0);
        check({name, " hold in idle"}, data_out, exp_d);
    endtask

    vec_t vecs[$];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        start   = 1'b0;
        op      = 3'b000;
        shamt   = 5'd0;
        data_in = 32'd0;
        reset   = 1'b1;

        vecs.push_back('{3'b001, 5'd4,  32'h0000_0001, 32'h0000_0010, 5,  "sll4"});
        vecs.push_back('{3'b011, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 32, "sra31"});
        vecs.push_back('{3'b010, 5'd31, 32'h8000_0000, 32'h0000_0001, 32, "srl31"});
        vecs.push_back('{3'b101, 5'd4,  32'h0000_00F1, 32'h1000_000F, 5,  "ror4"});
        vecs.push_back('{3'b100, 5'd0,  32'h0000_00F1, 32'h0000_00F1, 1,  "rol0"});
        vecs.push_back('{3'b110, 5'd7,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1,  "reserved6"});
        vecs.push_back('{3'b111, 5'd3,  32'h1234_5678, 32'h1234_5678, 1,  "reserved7"});
        vecs.push_back('{3'b000, 5'd5,  32'hCAFE_F00D, 32'hCAFE_F00D, 1,  "nop5"});
        vecs.push_back('{3'b100, 5'd1,  32'h8000_0001, 32'h0000_0003, 2,  "rol1"});
        vecs.push_back('{3'b011, 5'd4,  32'h8000_0000, 32'hF800_0000, 5,  "sra4"});
        vecs.push_back('{3'b001, 5'd31, 32'hFFFF_FFFF, 32'h8000_0000, 32, "sll31"});
        vecs.push_back('{3'b101, 5'd31, 32'h0000_0001, 32'h0000_0002, 32, "ror31"});

        repeat (2) @(negedge clk);
        check("reset data_out", data_out, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        reset = 1'b0;

        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].shamt, vecs[i].data, vecs[i].exp_data, vecs[i].exp_lat, vecs[i].name);

        // Back-to-back: start held high, second op accepted in the DONE cycle.
        @(negedge clk);
        start = 1'b1; op = 3'b001; shamt = 5'd1; data_in = 32'h1;
        @(posedge clk);
        @(negedge clk);
        check("b2b first busy", {31'd0, busy}, 32'd1);
        op = 3'b010; shamt = 5'd1; data_in = 32'h4;
        @(negedge clk);
        check("b2b first done", {31'd0, done}, 32'd1);
        check("b2b first data", data_out, 32'h2);
        @(negedge clk);
        check("b2b second busy", {31'd0, busy}, 32'd1);
        check("b2b no gap done low", {31'd0, done}, 32'd0);
        start = 1'b0;
        @(negedge clk);
        check("b2b second done", {31'd0, done}, 32'd1);
        check("b2b second data", data_out, 32'h2);
        @(negedge clk);
        check("b2b back to idle", {30'd0, busy, done}, 32'd0);

        // A start pulse during SHIFT must not restart the operation.
        @(negedge clk);
        start = 1'b1; op = 3'b001; shamt = 5'd3; data_in = 32'h1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; op = 3'b010; shamt = 5'd9; data_in = 32'hFFFF_0000;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("ignore start done", {31'd0, done}, 32'd1);
        check("ignore start data", data_out, 32'h8);
        @(negedge clk);
        check("ignore start single pulse", {30'd0, busy, done}, 32'd0);

        // Asynchronous reset in the middle of a shift.
        @(negedge clk);
        start = 1'b1; op = 3'b001; shamt = 5'd10; data_in = 32'h1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("midshift data", data_out, 32'h8);
        check("midshift busy", {31'd0, busy}, 32'd1);
        #1 reset = 1'b1;
        #1;
        check("async reset data", data_out, 32'd0);
        check("async reset flags", {30'd0, busy, done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        begin
            int seen;
            seen = 0;
            repeat (15) begin
                @(negedge clk);
                if (done || busy) seen++;
            end
            check("no done after reset", 32'(seen), 32'd0);
        end
        run_op(3'b001, 5'd10, 32'h1, 32'h0000_0400, 11, "after reset sll10");

        // Random operations against the arithmetic model.
        for (int k = 0; k < 40; k++) begin
            logic [2:0]  ro;
            logic [4:0]  rs;
            logic [31:0] rd;
            ro = 3'($urandom_range(0, 7));
            rs = 5'($urandom_range(0, 31));
            rd = $urandom;
            run_op(ro, rs, rd, model(ro, rs, rd), model_lat(ro, rs), $sformatf("rand%0d op%0d sh%0d", k, ro, rs));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
